// File: rtl/mem_fpu_arbiter_pkg.sv
// Shared constants and types for the multi-channel FPU MMIO arbiter:
// register offsets, status bit positions and the per-channel FSM state.
package mem_fpu_arbiter_pkg;

    localparam logic [1:0] REG_A   = 2'd0;
    localparam logic [1:0] REG_B   = 2'd1;
    localparam logic [1:0] REG_CMD = 2'd2;
    localparam logic [1:0] REG_RES = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_TIMEOUT = 3;
    localparam int STAT_W       = 4;

    localparam logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } fsm_state_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chan_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_fpu_arbiter_n_channel.sv
// One FPU channel: operand/command/result registers, the launch/wait FSM
// and its timeout counter.
module fpu_channel_ctrl
    import mem_fpu_arbiter_pkg::*;
#(
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_a_i,
    input  logic              wr_b_i,
    input  logic              wr_cmd_i,
    input  logic [31:0]       wr_data_i,
    input  logic              rd_res_i,
    input  logic              fpu_done_i,
    input  logic [31:0]       fpu_result_i,
    output logic              fpu_start_o,
    output logic [OP_W-1:0]   fpu_op_o,
    output logic [31:0]       fpu_a_o,
    output logic [31:0]       fpu_b_o,
    output logic [STAT_W-1:0] status_o,
    output logic [31:0]       result_o
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    fsm_state_e         state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        result_q, result_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               to_q, to_d;

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            timer_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    // NOTE: every _d gets its hold value first, so no branch can infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = wr_a_i ? wr_data_i : a_q;
        b_d      = wr_b_i ? wr_data_i : b_q;
        result_d = result_q;
        timer_d  = timer_q;
        done_d   = rd_res_i ? 1'b0 : done_q;
        err_d    = err_q;
        to_d     = to_q;

        case (state_q)
            IDLE: begin
                if (wr_cmd_i) begin
                    op_d    = wr_data_i[OP_W-1:0];
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT;
                if (wr_cmd_i) err_d = 1'b1;
            end
            WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (wr_cmd_i) err_d = 1'b1;
                // A real completion on the last cycle beats the timeout.
                if (fpu_done_i) begin
                    result_d = fpu_result_i;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    result_d = TIMEOUT_RESULT;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    to_d     = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        status_o               = '0;
        status_o[STAT_BUSY]    = (state_q != IDLE);
        status_o[STAT_DONE]    = done_q;
        status_o[STAT_ERR]     = err_q;
        status_o[STAT_TIMEOUT] = to_q;
        fpu_start_o            = (state_q == LAUNCH);
    end

    assign fpu_op_o = op_q;
    assign fpu_a_o  = a_q;
    assign fpu_b_o  = b_q;
    assign result_o = result_q;

endmodule

// File: rtl/mem_fpu_arbiter_n.sv
// CPU/dmem arbiter exposing NUM_FPU FPU channels in an MMIO window; all other
// accesses pass straight through to data memory.
module mem_fpu_arbiter_n
    import mem_fpu_arbiter_pkg::*;
#(
    parameter int          NUM_FPU   = 2,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000,
    parameter int          OP_W      = 3,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [31:0]             io_cpu_rdAddress,
    output logic [31:0]             io_cpu_rdData,
    input  logic [31:0]             io_cpu_wrAddress,
    input  logic [31:0]             io_cpu_wrData,
    input  logic [3:0]              io_cpu_wrEnable,
    output logic [31:0]             io_dmem_rdAddress,
    input  logic [31:0]             io_dmem_rdData,
    output logic [31:0]             io_dmem_wrAddress,
    output logic [31:0]             io_dmem_wrData,
    output logic [3:0]              io_dmem_wrEnable,
    output logic [NUM_FPU-1:0]      io_fpu_start,
    output logic [NUM_FPU*OP_W-1:0] io_fpu_op,
    output logic [NUM_FPU*32-1:0]   io_fpu_a,
    output logic [NUM_FPU*32-1:0]   io_fpu_b,
    input  logic [NUM_FPU*32-1:0]   io_fpu_result,
    input  logic [NUM_FPU-1:0]      io_fpu_done
);

    localparam int CH_W = chan_idx_w(NUM_FPU);

    logic [27:0]     wr_off, rd_off;
    logic            wr_hit, rd_hit, wr_full;
    logic [CH_W-1:0] wr_ch, rd_ch;
    logic [1:0]      wr_reg, rd_reg;

    logic [STAT_W-1:0] ch_status [NUM_FPU];
    logic [31:0]       ch_result [NUM_FPU];

    logic        rd_hit_q, rd_hit_d;
    logic [31:0] rd_data_q, rd_data_d;

    // Unsigned offset in 16-byte units; addresses below the base wrap to large values.
    assign wr_off  = io_cpu_wrAddress[31:4] - MMIO_BASE[31:4];
    assign rd_off  = io_cpu_rdAddress[31:4] - MMIO_BASE[31:4];
    assign wr_hit  = (wr_off < 28'(NUM_FPU));
    assign rd_hit  = (rd_off < 28'(NUM_FPU));
    assign wr_ch   = wr_off[CH_W-1:0];
    assign rd_ch   = rd_off[CH_W-1:0];
    assign wr_reg  = io_cpu_wrAddress[3:2];
    assign rd_reg  = io_cpu_rdAddress[3:2];
    assign wr_full = wr_hit && (io_cpu_wrEnable == 4'hF);

    assign io_dmem_rdAddress = io_cpu_rdAddress;
    assign io_dmem_wrAddress = io_cpu_wrAddress;
    assign io_dmem_wrData    = io_cpu_wrData;
    assign io_dmem_wrEnable  = wr_hit ? 4'h0 : io_cpu_wrEnable;

    for (genvar c = 0; c < NUM_FPU; c++) begin : g_ch
        logic sel_wr, sel_rd;
        assign sel_wr = wr_full && (wr_ch == CH_W'(c));
        assign sel_rd = rd_hit && (rd_ch == CH_W'(c));

        fpu_channel_ctrl #(
            .OP_W    (OP_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk          (clock),
            .rst_n        (reset_n),
            .wr_a_i       (sel_wr && (wr_reg == REG_A)),
            .wr_b_i       (sel_wr && (wr_reg == REG_B)),
            .wr_cmd_i     (sel_wr && (wr_reg == REG_CMD)),
            .wr_data_i    (io_cpu_wrData),
            .rd_res_i     (sel_rd && (rd_reg == REG_RES)),
            .fpu_done_i   (io_fpu_done[c]),
            .fpu_result_i (io_fpu_result[c*32 +: 32]),
            .fpu_start_o  (io_fpu_start[c]),
            .fpu_op_o     (io_fpu_op[c*OP_W +: OP_W]),
            .fpu_a_o      (io_fpu_a[c*32 +: 32]),
            .fpu_b_o      (io_fpu_b[c*32 +: 32]),
            .status_o     (ch_status[c]),
            .result_o     (ch_result[c])
        );
    end

    // The MMIO value is snapshotted on the address cycle, so a RESULT read that
    // coincides with a completion returns the pre-completion result.
    always_comb begin
        rd_hit_d  = rd_hit;
        rd_data_d = '0;
        if (rd_hit) begin
            case (rd_reg)
                REG_CMD: rd_data_d = 32'(ch_status[rd_ch]);
                REG_RES: rd_data_d = ch_result[rd_ch];
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_hit_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_hit_q  <= rd_hit_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Reset also masks the dmem path so the CPU sees zero while held in reset.
    assign io_cpu_rdData = !reset_n ? 32'h0 : (rd_hit_q ? rd_data_q : io_dmem_rdData);

endmodule

// File: tb/tb_mem_fpu_arbiter_n.sv
// Self-checking bench for mem_fpu_arbiter_n: two channels, short timeout,
// read results checked through a scoreboard queue.
module tb_mem_fpu_arbiter_n;

    localparam int          NUM_FPU = 2;
    localparam int          OP_W    = 3;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] BASE    = 32'hF000_0000;
    localparam logic [31:0] NEUTRAL = 32'h0000_0200;

    logic                    clock;
    logic                    reset_n;
    logic [31:0]             io_cpu_rdAddress;
    logic [31:0]             io_cpu_rdData;
    logic [31:0]             io_cpu_wrAddress;
    logic [31:0]             io_cpu_wrData;
    logic [3:0]              io_cpu_wrEnable;
    logic [31:0]             io_dmem_rdAddress;
    logic [31:0]             io_dmem_rdData;
    logic [31:0]             io_dmem_wrAddress;
    logic [31:0]             io_dmem_wrData;
    logic [3:0]              io_dmem_wrEnable;
    logic [NUM_FPU-1:0]      io_fpu_start;
    logic [NUM_FPU*OP_W-1:0] io_fpu_op;
    logic [NUM_FPU*32-1:0]   io_fpu_a;
    logic [NUM_FPU*32-1:0]   io_fpu_b;
    logic [NUM_FPU*32-1:0]   io_fpu_result;
    logic [NUM_FPU-1:0]      io_fpu_done;

    mem_fpu_arbiter_n #(
        .NUM_FPU   (NUM_FPU),
        .MMIO_BASE (BASE),
        .OP_W      (OP_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .io_cpu_rdAddress  (io_cpu_rdAddress),
        .io_cpu_rdData     (io_cpu_rdData),
        .io_cpu_wrAddress  (io_cpu_wrAddress),
        .io_cpu_wrData     (io_cpu_wrData),
        .io_cpu_wrEnable   (io_cpu_wrEnable),
        .io_dmem_rdAddress (io_dmem_rdAddress),
        .io_dmem_rdData    (io_dmem_rdData),
        .io_dmem_wrAddress (io_dmem_wrAddress),
        .io_dmem_wrData    (io_dmem_wrData),
        .io_dmem_wrEnable  (io_dmem_wrEnable),
        .io_fpu_start      (io_fpu_start),
        .io_fpu_op         (io_fpu_op),
        .io_fpu_a          (io_fpu_a),
        .io_fpu_b          (io_fpu_b),
        .io_fpu_result     (io_fpu_result),
        .io_fpu_done       (io_fpu_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    int start_cnt [NUM_FPU] = '{default: 0};
    always @(negedge clock) begin
        for (int c = 0; c < NUM_FPU; c++)
            if (io_fpu_start[c] === 1'b1) start_cnt[c]++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ra(input int ch, input int r);
        return BASE + 32'(16 * ch) + 32'(4 * r);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One write cycle; also checks what dmem sees as its write enable.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] en, input logic [3:0] exp_dmem_en, input string tag);
        io_cpu_wrAddress = addr;
        io_cpu_wrData    = data;
        io_cpu_wrEnable  = en;
        #1;
        check({tag, "_dmem_we"}, 32'(io_dmem_wrEnable), 32'(exp_dmem_en));
        @(posedge clock);
        #1;
        io_cpu_wrEnable  = 4'h0;
        io_cpu_wrAddress = NEUTRAL;
    endtask

    // Address cycle pushes the expectation; the data cycle pops and compares.
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag,
                      input logic [31:0] dmem_val);
        exp_t e;
        io_cpu_rdAddress = addr;
        e.tag = tag;
        e.val = exp;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        io_cpu_rdAddress = NEUTRAL;
        io_dmem_rdData   = dmem_val;
        #1;
        e = sb_q.pop_front();
        check(e.tag, io_cpu_rdData, e.val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        io_cpu_rdAddress = NEUTRAL;
        io_cpu_wrAddress = NEUTRAL;
        io_cpu_wrData    = '0;
        io_cpu_wrEnable  = '0;
        io_dmem_rdData   = 32'h7777_7777;
        io_fpu_result    = '0;
        io_fpu_done      = '0;
        step(2);
        check("rst_start",  32'(io_fpu_start), 32'h0);
        check("rst_rddata", io_cpu_rdData, 32'h0);
        check("rst_op",     32'(io_fpu_op), 32'h0);
        reset_n        = 1'b1;
        io_dmem_rdData = '0;
        step(1);

        // Passthrough and window boundaries
        wr(32'h0000_0100, 32'h0000_1234, 4'hF, 4'hF, "pass_wr");
        io_cpu_rdAddress = 32'h0000_0100;
        #1;
        check("pass_rdaddr", io_dmem_rdAddress, 32'h0000_0100);
        rd(32'h0000_0100, 32'hCAFE_F00D, "pass_rd", 32'hCAFE_F00D);
        wr(ra(2, 0), 32'h55, 4'hF, 4'hF, "above_win");
        wr(32'hEFFF_FFF0, 32'h66, 4'hF, 4'hF, "below_win");

        // Launch and complete on channel 1
        wr(ra(1, 0), 32'h3F80_0000, 4'hF, 4'h0, "c1_a");
        wr(ra(1, 1), 32'h4000_0000, 4'hF, 4'h0, "c1_b");
        wr(ra(1, 2), 32'h0, 4'hF, 4'h0, "c1_cmd");
        check("c1_start", 32'(io_fpu_start), 32'h2);
        check("c1_a_out", io_fpu_a[63:32], 32'h3F80_0000);
        check("c1_b_out", io_fpu_b[63:32], 32'h4000_0000);
        rd(ra(1, 2), 32'h1, "c1_stat_busy", 32'h0);
        step(2);
        io_fpu_result[63:32] = 32'h4040_0000;
        io_fpu_done          = 2'b10;
        step(1);
        io_fpu_done   = '0;
        io_fpu_result = '0;
        rd(ra(1, 2), 32'h2, "c1_stat_done", 32'h0);
        rd(ra(1, 3), 32'h4040_0000, "c1_result", 32'h0);
        rd(ra(1, 2), 32'h0, "c1_stat_clr", 32'h0);
        rd(ra(1, 0), 32'h0, "c1_rd_wonly", 32'h0);
        check("c1_start_cnt", 32'(start_cnt[1]), 32'd1);

        // CMD while busy on channel 0
        wr(ra(0, 2), 32'h5, 4'hF, 4'h0, "c0_cmd");
        wr(ra(0, 2), 32'h3, 4'hF, 4'h0, "c0_cmd_busy");
        rd(ra(0, 2), 32'h5, "c0_stat_err", 32'h0);
        check("c0_op_kept", 32'(io_fpu_op[2:0]), 32'h5);
        step(1);
        io_fpu_result[31:0] = 32'h1111_1111;
        io_fpu_done         = 2'b01;
        step(1);
        io_fpu_done   = '0;
        io_fpu_result = '0;
        rd(ra(0, 2), 32'h6, "c0_stat_done_err", 32'h0);
        rd(ra(0, 3), 32'h1111_1111, "c0_result", 32'h0);
        rd(ra(0, 2), 32'h4, "c0_stat_err_only", 32'h0);
        check("c0_start_cnt", 32'(start_cnt[0]), 32'd1);

        // Timeout on channel 0: last WAIT cycle still busy, then forced completion
        wr(ra(0, 2), 32'h2, 4'hF, 4'h0, "to_cmd");
        step(8);
        rd(ra(0, 2), 32'h1, "to_last_wait", 32'h0);
        rd(ra(0, 2), 32'hE, "to_stat", 32'h0);
        rd(ra(0, 3), 32'hFFFF_FFFF, "to_result", 32'h0);
        rd(ra(0, 2), 32'hC, "to_stat_rdclr", 32'h0);
        check("to_start_cnt", 32'(start_cnt[0]), 32'd2);

        // Simultaneous completions with a coinciding RESULT read of channel 0
        wr(ra(0, 2), 32'h1, 4'hF, 4'h0, "cc_cmd0");
        wr(ra(1, 2), 32'h4, 4'hF, 4'h0, "cc_cmd1");
        step(2);
        io_fpu_result = {32'hBBBB_0000, 32'hAAAA_0000};
        io_fpu_done   = 2'b11;
        rd(ra(0, 3), 32'hFFFF_FFFF, "cc_old_result", 32'h0);
        io_fpu_done   = '0;
        io_fpu_result = '0;
        rd(ra(0, 2), 32'h2, "cc_stat0", 32'h0);
        rd(ra(1, 2), 32'h2, "cc_stat1", 32'h0);
        rd(ra(0, 3), 32'hAAAA_0000, "cc_res0", 32'h0);
        rd(ra(1, 3), 32'hBBBB_0000, "cc_res1", 32'h0);

        // Done while IDLE is ignored
        io_fpu_result[31:0] = 32'h9999_9999;
        io_fpu_done         = 2'b01;
        step(1);
        io_fpu_done   = '0;
        io_fpu_result = '0;
        rd(ra(0, 2), 32'h0, "idle_done_stat", 32'h0);
        rd(ra(0, 3), 32'hAAAA_0000, "idle_done_res", 32'h0);

        // Partial writes into the window are dropped
        wr(ra(0, 0), 32'h1234_5678, 4'hF, 4'h0, "pw_full");
        check("pw_a_full", io_fpu_a[31:0], 32'h1234_5678);
        wr(ra(0, 0), 32'hDEAD_BEEF, 4'b0011, 4'h0, "pw_part");
        check("pw_a_kept", io_fpu_a[31:0], 32'h1234_5678);
        wr(ra(0, 2), 32'h0, 4'b1110, 4'h0, "pw_cmd");
        check("pw_no_start", 32'(io_fpu_start), 32'h0);
        rd(ra(0, 2), 32'h0, "pw_stat", 32'h0);

        // Asynchronous reset in the middle of WAIT
        wr(ra(1, 2), 32'h1, 4'hF, 4'h0, "rw_cmd");
        step(2);
        #2;
        io_dmem_rdData = 32'h5555_AAAA;
        reset_n        = 1'b0;
        #1;
        check("rw_start",  32'(io_fpu_start), 32'h0);
        check("rw_op",     32'(io_fpu_op), 32'h0);
        check("rw_a1",     io_fpu_a[63:32], 32'h0);
        check("rw_b1",     io_fpu_b[63:32], 32'h0);
        check("rw_rddata", io_cpu_rdData, 32'h0);
        step(1);
        reset_n = 1'b1;
        io_fpu_result[63:32] = 32'h0000_0077;
        io_fpu_done          = 2'b10;
        step(1);
        io_fpu_done   = '0;
        io_fpu_result = '0;
        rd(ra(1, 2), 32'h0, "rw_late_stat", 32'h0);
        rd(ra(1, 3), 32'h0, "rw_late_res", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
